if0_fetch_ctrl: RTL

//  Fetch-PC sequencer for the IF0 stage. Owns fetch_pc/pc_next, issues one I-cache request per

---
 rtl/if0_fetch_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/if0_fetch_ctrl.sv
// IF0 fetch-PC sequencer: owns fetch_pc, issues one I-cache request per fetch block,
// arbitrates redirects (exception > branch > predictor) and parks fetch on IDLE.
module if0_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h1C00_0000,
    parameter int          FETCH_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_excp,
    input  logic [31:0] excp_target,
    input  logic        flush_br,
    input  logic [31:0] br_target,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic        idle_req,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_addr_ok,
    output logic        icache_cancel,
    input  logic        if0_allowin,
    output logic        if0_readygo,
    output logic [31:0] fetch_pc,
    output logic [31:0] pc_next,
    output logic        flush
);

    localparam logic [31:0] BLK_BYTES = 32'(FETCH_WIDTH * 4);
    localparam logic [31:0] BLK_MASK  = BLK_BYTES - 32'd1;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_IDLE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] fetch_pc_reg;
    logic        idle_pend_reg;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] excp_pc;

    assign redirect = flush_excp | flush_br | pred_taken;
    assign flush    = flush_excp | flush_br;
    assign excp_pc  = excp_target & ~32'h3;

    always_comb begin
        redirect_target = pred_target & ~32'h3;
        if (flush_excp) begin
            redirect_target = excp_pc;
        end else if (flush_br) begin
            redirect_target = br_target & ~32'h3;
        end
    end

    assign fetch_pc    = fetch_pc_reg;
    assign icache_addr = fetch_pc_reg;
    assign pc_next     = (fetch_pc_reg & ~BLK_MASK) + BLK_BYTES;

    // Handshake outputs react to this cycle's redirects, so they are decoded from the
    // registered state; they are held low while reset is asserted.
    always_comb begin
        icache_req    = 1'b0;
        if0_readygo   = 1'b0;
        icache_cancel = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_REQ: begin
                    icache_req    = ~redirect;
                    // A block abandoned for IDLE is never handed to IF1.
                    if0_readygo   = icache_addr_ok & ~redirect & ~idle_req;
                    icache_cancel = icache_addr_ok & (redirect | idle_req);
                end
                ST_HOLD: begin
                    if0_readygo   = ~redirect;
                    icache_cancel = redirect;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_REQ;
            fetch_pc_reg  <= RESET_PC;
            idle_pend_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_REQ: begin
                    if (redirect) begin
                        fetch_pc_reg <= redirect_target;
                    end else if (idle_req) begin
                        state_reg <= ST_IDLE;
                    end else if (icache_addr_ok) begin
                        if (if0_allowin) begin
                            fetch_pc_reg <= pc_next;
                        end else begin
                            state_reg <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        fetch_pc_reg  <= redirect_target;
                        state_reg     <= ST_REQ;
                        idle_pend_reg <= 1'b0;
                    end else if (if0_allowin) begin
                        fetch_pc_reg  <= pc_next;
                        state_reg     <= (idle_req | idle_pend_reg) ? ST_IDLE : ST_REQ;
                        idle_pend_reg <= 1'b0;
                    end else begin
                        // IDLE pulse seen while the block waits; honour it after transfer.
                        idle_pend_reg <= idle_pend_reg | idle_req;
                    end
                end
                ST_IDLE: begin
                    if (flush_excp) begin
                        fetch_pc_reg <= excp_pc;
                        state_reg    <= ST_REQ;
                    end
                end
                default: begin
                    state_reg <= ST_REQ;
                end
            endcase
        end
    end

endmodule
